alu_chunk_sequencer: RTL and testbench
======================================

// Module: alu_chunk_sequencer
// PURPOSE
//  Multi-cycle controller that executes WIDTH-bit ALU operations on the shared 6-bit ALU
//  (six 1-bit slices, external to this block). It is fed by a valid/ready request port.
//  It drives one 6-bit chunk per cycle, LSB chunk first, and chains carry between chunks.
//  It then returns the assembled result and flags on a valid/ready response port.
// PARAMETERS
//  WIDTH   24   operand/result width; must be a multiple of SLICE
//  SLICE   6    ALU datapath width (fixed by the ALU); NCHUNK = WIDTH/SLICE
// PORTS
//  clk            in   1       clock, rising edge
//  reset          in   1       asynchronous, active-high reset
//  req_valid      in   1       request present
//  req_ready      out  1       block can accept a request (high only in IDLE)
//  req_op         in   4       ALUOp: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 1100 NOR
//  req_a, req_b   in   WIDTH   operands
//  alu_a, alu_b   out  SLICE   current chunk of operands to the ALU
//  alu_op         out  4       ALUOp to the ALU
//  alu_carry_in   out  1       carry into chunk's bit 0
//  alu_result     in   SLICE   ALU result for the current chunk (combinational)
//  alu_carry_out  in   1       ALU carry out of bit SLICE-1
//  rsp_valid      out  1       result available; held until rsp_ready
//  rsp_ready      in   1       consumer accepts result
//  rsp_result     out  WIDTH   assembled result
//  rsp_carry      out  1       final carry (ADD/SUB only; SUB: 1 = no borrow), else 0
//  rsp_ovf        out  1       signed overflow (ADD/SUB only), else 0
//  rsp_zero       out  1       rsp_result == 0
//  rsp_err        out  1       req_op not in the legal set
// BEHAVIOUR
//  - Reset (async): state=IDLE, chunk index=0, operand/result regs=0, all outputs 0
//    except req_ready=1. An in-flight operation is discarded, and no response is produced.
//  - FSM: IDLE -> RUN on req_valid&req_ready (legal op). Illegal op: IDLE -> DONE, rsp_err=1,
//    rsp_result=0, all flags 0 except rsp_zero=1, and the ALU is not driven.
//  - RUN: cycle k (k=0..NCHUNK-1) drives alu_a/b = operand bits [k*SLICE +: SLICE], alu_op=op.
//    alu_carry_in: k=0 -> 1 for SUB, 0 otherwise. k>0 -> registered alu_carry_out for
//    ADD/SUB, 0 for logic ops. alu_result is captured into chunk k at the clock edge.
//    After k=NCHUNK-1: RUN -> DONE.
//  - Outside RUN, alu_a/alu_b/alu_op/alu_carry_in are driven 0.
//  - Latency: rsp_valid rises NCHUNK+1 edges after the accepting edge, or 1 edge for an
//    illegal op. The response is registered.
//  - DONE: rsp_* stable while rsp_valid=1 and !rsp_ready. On rsp_ready: DONE -> IDLE,
//    rsp_valid=0 next cycle. The next request is accepted at the earliest one cycle later,
//    with no IDLE->DONE bypass.
//  - rsp_ovf: computed from the top chunk (MSB of a, MSB of b XOR sub, MSB of result), using
//    ovf = (a_msb == b_eff_msb) & (r_msb != a_msb).
//  - Operands are registered at accept; req_a/req_b/req_op changes during RUN are ignored.
//  - req_ready=0 throughout RUN and DONE; req_valid is never dropped or lost, only stalled.
// TESTING (WIDTH=24)
//  1. ADD 0xFFFFFF+0x000001 -> result 0x000000, carry=1, zero=1, ovf=0. rsp_valid 5 edges
//     after accept, with carry_in chain 0,1,1,1 observed.
//  2. SUB 0x000000-0x000001 -> 0xFFFFFF, carry=0, ovf=0. SUB 0x800000-0x000001 -> 0x7FFFFF,
//     ovf=1.
//  3. ADD 0x7FFFFF+0x000001 -> 0x800000, ovf=1, carry=0.
//     AND 0xF0F0F0&0xFF00FF -> 0xF000F0, carry=0.
//  4. Hold rsp_ready=0 for 6 cycles after rsp_valid -> rsp_* unchanged and req_ready=0.
//     Then pulse rsp_ready -> IDLE, and a back-to-back request is accepted 1 cycle later.
//  5. req_op=4'b1111 -> rsp_err=1, result 0, rsp_valid 1 edge after accept, alu_* all 0.
//  6. Assert reset during RUN chunk 2 -> all outputs reset immediately (async), req_ready=1.
//     The next ADD 0x000003+0x000004 returns 0x000007 correctly.

Source files
------------

// File: rtl/alu_chunk_sequencer.sv
// alu_chunk_sequencer: runs WIDTH-bit ALU operations on an external SLICE-bit ALU.
// It handles one chunk per cycle, starting with the LSB chunk, and chains the carry
// between chunks. Requests arrive and responses leave on valid/ready handshakes.
// Every output is driven directly from a register.
module alu_chunk_sequencer #(
  parameter int WIDTH = 24,
  parameter int SLICE = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic [SLICE-1:0] alu_a,
  output logic [SLICE-1:0] alu_b,
  output logic [3:0]       alu_op,
  output logic             alu_carry_in,
  input  logic [SLICE-1:0] alu_result,
  input  logic             alu_carry_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_ovf,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam int NCHUNK = WIDTH / SLICE;
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0110;
  localparam logic [3:0] OP_NOR = 4'b1100;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Returns 1 when the opcode is one of the ALU operations this block supports.
  function automatic logic op_legal(input logic [3:0] op);
    logic ok;
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_NOR: ok = 1'b1;
      default:                               ok = 1'b0;
    endcase
    return ok;
  endfunction

  state_t           state_r, state_nx_s;
  logic [IW-1:0]    idx_r;
  logic [WIDTH-1:0] a_r, b_r, res_r;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] res_s, a_nx_s, b_nx_s;
  logic             req_legal_s, run_arith_s, run_sub_s, last_s, ovf_s;

  logic             req_ready_r, alu_cin_r, rsp_valid_r;
  logic [SLICE-1:0] alu_a_r, alu_b_r;
  logic [3:0]       alu_op_r;
  logic [WIDTH-1:0] rsp_result_r;
  logic             rsp_carry_r, rsp_ovf_r, rsp_zero_r, rsp_err_r;

  assign req_ready    = req_ready_r;
  assign alu_a        = alu_a_r;
  assign alu_b        = alu_b_r;
  assign alu_op       = alu_op_r;
  assign alu_carry_in = alu_cin_r;
  assign rsp_valid    = rsp_valid_r;
  assign rsp_result   = rsp_result_r;
  assign rsp_carry    = rsp_carry_r;
  assign rsp_ovf      = rsp_ovf_r;
  assign rsp_zero     = rsp_zero_r;
  assign rsp_err      = rsp_err_r;

  // Decode the opcode, find the next operand chunk and merge the current ALU chunk into the result.
  always_comb begin
    req_legal_s = op_legal(req_op);
    run_arith_s = (op_r == OP_ADD) || (op_r == OP_SUB);
    run_sub_s   = (op_r == OP_SUB);
    last_s      = (idx_r == IW'(NCHUNK - 1));
    a_nx_s      = a_r >> (SLICE * (int'(idx_r) + 1));
    b_nx_s      = b_r >> (SLICE * (int'(idx_r) + 1));
    res_s       = res_r;
    res_s[int'(idx_r)*SLICE +: SLICE] = alu_result;
    ovf_s = (a_r[WIDTH-1] == (b_r[WIDTH-1] ^ run_sub_s)) &&
            (alu_result[SLICE-1] != a_r[WIDTH-1]);
  end

  // Next-state logic for the control FSM.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      IDLE: begin
        if (req_valid) begin
          state_nx_s = req_legal_s ? RUN : DONE;
        end else begin
          state_nx_s = IDLE;
        end
      end
      RUN: begin
        if (last_s) begin
          state_nx_s = DONE;
        end else begin
          state_nx_s = RUN;
        end
      end
      DONE: begin
        if (rsp_ready) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = DONE;
        end
      end
      default: state_nx_s = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Datapath: capture the operands, step through the chunks and register the response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_r        <= {IW{1'b0}};
      a_r          <= {WIDTH{1'b0}};
      b_r          <= {WIDTH{1'b0}};
      op_r         <= 4'b0000;
      res_r        <= {WIDTH{1'b0}};
      req_ready_r  <= 1'b1;
      alu_a_r      <= {SLICE{1'b0}};
      alu_b_r      <= {SLICE{1'b0}};
      alu_op_r     <= 4'b0000;
      alu_cin_r    <= 1'b0;
      rsp_valid_r  <= 1'b0;
      rsp_result_r <= {WIDTH{1'b0}};
      rsp_carry_r  <= 1'b0;
      rsp_ovf_r    <= 1'b0;
      rsp_zero_r   <= 1'b0;
      rsp_err_r    <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            req_ready_r <= 1'b0;
            if (req_legal_s) begin
              a_r       <= req_a;
              b_r       <= req_b;
              op_r      <= req_op;
              idx_r     <= {IW{1'b0}};
              res_r     <= {WIDTH{1'b0}};
              alu_a_r   <= req_a[SLICE-1:0];
              alu_b_r   <= req_b[SLICE-1:0];
              alu_op_r  <= req_op;
              alu_cin_r <= (req_op == OP_SUB);
            end else begin
              // An illegal opcode skips the ALU and answers with a zero result at once.
              rsp_valid_r  <= 1'b1;
              rsp_err_r    <= 1'b1;
              rsp_result_r <= {WIDTH{1'b0}};
              rsp_zero_r   <= 1'b1;
              rsp_carry_r  <= 1'b0;
              rsp_ovf_r    <= 1'b0;
            end
          end
        end
        RUN: begin
          res_r <= res_s;
          if (last_s) begin
            alu_a_r      <= {SLICE{1'b0}};
            alu_b_r      <= {SLICE{1'b0}};
            alu_op_r     <= 4'b0000;
            alu_cin_r    <= 1'b0;
            rsp_valid_r  <= 1'b1;
            rsp_err_r    <= 1'b0;
            rsp_result_r <= res_s;
            rsp_zero_r   <= (res_s == {WIDTH{1'b0}});
            rsp_carry_r  <= run_arith_s ? alu_carry_out : 1'b0;
            rsp_ovf_r    <= run_arith_s ? ovf_s : 1'b0;
          end else begin
            idx_r     <= idx_r + IW'(1);
            alu_a_r   <= a_nx_s[SLICE-1:0];
            alu_b_r   <= b_nx_s[SLICE-1:0];
            alu_cin_r <= run_arith_s ? alu_carry_out : 1'b0;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid_r <= 1'b0;
            req_ready_r <= 1'b1;
          end
        end
        default: begin
          req_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_chunk_sequencer.sv
// Testbench for alu_chunk_sequencer (WIDTH=24). It contains a behavioural 6-bit ALU
// and runs directed scenarios whose expected values were worked out by hand.
module tb_alu_chunk_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [3:0]  req_op;
  logic [23:0] req_a, req_b;
  logic [5:0]  alu_a, alu_b, alu_result;
  logic [3:0]  alu_op;
  logic        alu_carry_in, alu_carry_out;
  logic        rsp_valid, rsp_ready;
  logic [23:0] rsp_result;
  logic        rsp_carry, rsp_ovf, rsp_zero, rsp_err;
  logic [6:0]  sum;

  int checks = 0;
  int errors = 0;

  alu_chunk_sequencer #(.WIDTH(24), .SLICE(6)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_carry_in(alu_carry_in),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_ovf(rsp_ovf), .rsp_zero(rsp_zero), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  // Behavioural model of the external 6-bit ALU.
  always_comb begin
    sum = 7'd0;
    alu_result = 6'd0;
    alu_carry_out = 1'b0;
    case (alu_op)
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      4'b0010: begin
        sum = {1'b0, alu_a} + {1'b0, alu_b} + {6'd0, alu_carry_in};
        alu_result = sum[5:0];
        alu_carry_out = sum[6];
      end
      4'b0110: begin
        sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {6'd0, alu_carry_in};
        alu_result = sum[5:0];
        alu_carry_out = sum[6];
      end
      4'b1100: alu_result = ~(alu_a | alu_b);
      default: alu_result = 6'd0;
    endcase
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // Present one request, then count edges (accepting edge = 1) until rsp_valid rises.
  task automatic send(input logic [3:0] op, input logic [23:0] a, input logic [23:0] b,
                      output int lat);
    int n;
    n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1;
    step();
    req_valid = 1'b0; req_op = 4'b0001; req_a = 24'h5A5A5A; req_b = 24'hA5A5A5;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
  endtask

  task automatic release_rsp;
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++; $display("FAIL reset_handshake ready=%b valid=%b want 1 0", req_ready, rsp_valid);
    end
    checks++;
    if (alu_a !== 6'd0 || alu_b !== 6'd0 || alu_op !== 4'd0 || alu_carry_in !== 1'b0) begin
      errors++; $display("FAIL reset_alu a=%h b=%h op=%h cin=%b want 0", alu_a, alu_b, alu_op, alu_carry_in);
    end
    checks++;
    if ({rsp_result, rsp_carry, rsp_ovf, rsp_zero, rsp_err} !== 28'd0) begin
      errors++; $display("FAIL reset_rsp result=%h flags=%b%b%b%b want 0", rsp_result, rsp_carry, rsp_ovf, rsp_zero, rsp_err);
    end
  endtask

  task automatic test_add_carry;
    logic [3:0] chain;
    chain = 4'b1110;
    req_op = 4'b0010; req_a = 24'hFFFFFF; req_b = 24'h000001; req_valid = 1'b1;
    step();
    req_valid = 1'b0; req_a = 24'h123456; req_b = 24'h654321; req_op = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (alu_carry_in !== chain[k] || rsp_valid !== 1'b0 || alu_op !== 4'b0010) begin
        errors++; $display("FAIL add_chain k=%0d cin=%b valid=%b op=%h want %b 0 2", k, alu_carry_in, rsp_valid, alu_op, chain[k]);
      end
      step();
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      errors++; $display("FAIL add_latency valid=%b want 1 after 5 edges", rsp_valid);
    end
    checks++;
    if (rsp_result !== 24'h000000 || rsp_carry !== 1'b1 || rsp_zero !== 1'b1 || rsp_ovf !== 1'b0 || rsp_err !== 1'b0) begin
      errors++; $display("FAIL add_wrap result=%h c=%b z=%b v=%b e=%b want 000000 1 1 0 0", rsp_result, rsp_carry, rsp_zero, rsp_ovf, rsp_err);
    end
    release_rsp();
  endtask

  task automatic test_sub;
    int lat;
    send(4'b0110, 24'h000000, 24'h000001, lat);
    checks++;
    if (lat !== 5 || rsp_result !== 24'hFFFFFF || rsp_carry !== 1'b0 || rsp_ovf !== 1'b0 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL sub_borrow lat=%0d result=%h c=%b v=%b z=%b want 5 ffffff 0 0 0", lat, rsp_result, rsp_carry, rsp_ovf, rsp_zero);
    end
    release_rsp();
    send(4'b0110, 24'h800000, 24'h000001, lat);
    checks++;
    if (rsp_result !== 24'h7FFFFF || rsp_ovf !== 1'b1 || rsp_carry !== 1'b1) begin
      errors++; $display("FAIL sub_ovf result=%h v=%b c=%b want 7fffff 1 1", rsp_result, rsp_ovf, rsp_carry);
    end
    release_rsp();
  endtask

  task automatic test_add_ovf_and;
    int lat;
    send(4'b0010, 24'h7FFFFF, 24'h000001, lat);
    checks++;
    if (rsp_result !== 24'h800000 || rsp_ovf !== 1'b1 || rsp_carry !== 1'b0) begin
      errors++; $display("FAIL add_ovf result=%h v=%b c=%b want 800000 1 0", rsp_result, rsp_ovf, rsp_carry);
    end
    release_rsp();
    send(4'b0000, 24'hF0F0F0, 24'hFF00FF, lat);
    checks++;
    if (rsp_result !== 24'hF000F0 || rsp_carry !== 1'b0 || rsp_ovf !== 1'b0 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL and_op result=%h c=%b v=%b z=%b want f000f0 0 0 0", rsp_result, rsp_carry, rsp_ovf, rsp_zero);
    end
    release_rsp();
    send(4'b1100, 24'h0F0F0F, 24'h00FF00, lat);
    checks++;
    if (rsp_result !== 24'hF000F0 || rsp_carry !== 1'b0) begin
      errors++; $display("FAIL nor_op result=%h c=%b want f000f0 0", rsp_result, rsp_carry);
    end
    release_rsp();
  endtask

  task automatic test_back_to_back;
    int lat;
    send(4'b0010, 24'h000010, 24'h000020, lat);
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (rsp_valid !== 1'b1 || rsp_result !== 24'h000030 || req_ready !== 1'b0 || rsp_zero !== 1'b0) begin
        errors++; $display("FAIL hold cyc=%0d valid=%b result=%h ready=%b want 1 000030 0", i, rsp_valid, rsp_result, req_ready);
      end
    end
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL release valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    req_op = 4'b0001; req_a = 24'h0F0F0F; req_b = 24'h303030; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    checks++;
    if (req_ready !== 1'b0 || alu_op !== 4'b0001 || alu_a !== 6'h0F) begin
      errors++; $display("FAIL b2b_accept ready=%b op=%h a=%h want 0 1 0f", req_ready, alu_op, alu_a);
    end
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      step();
      lat++;
    end
    checks++;
    if (lat !== 5 || rsp_result !== 24'h3F3F3F || rsp_carry !== 1'b0) begin
      errors++; $display("FAIL b2b_or lat=%0d result=%h c=%b want 5 3f3f3f 0", lat, rsp_result, rsp_carry);
    end
    release_rsp();
  endtask

  task automatic test_illegal;
    int lat;
    send(4'b1111, 24'h123456, 24'h654321, lat);
    checks++;
    if (lat !== 1 || rsp_err !== 1'b1 || rsp_result !== 24'd0 || rsp_zero !== 1'b1 || rsp_carry !== 1'b0 || rsp_ovf !== 1'b0) begin
      errors++; $display("FAIL illegal lat=%0d e=%b result=%h z=%b c=%b v=%b want 1 1 0 1 0 0", lat, rsp_err, rsp_result, rsp_zero, rsp_carry, rsp_ovf);
    end
    checks++;
    if (alu_a !== 6'd0 || alu_b !== 6'd0 || alu_op !== 4'd0 || alu_carry_in !== 1'b0) begin
      errors++; $display("FAIL illegal_alu a=%h b=%h op=%h cin=%b want 0", alu_a, alu_b, alu_op, alu_carry_in);
    end
    release_rsp();
  endtask

  task automatic test_reset_midrun;
    int lat;
    req_op = 4'b0010; req_a = 24'h000FFF; req_b = 24'h000001; req_valid = 1'b1;
    step();
    req_valid = 1'b0;
    step();
    step();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || alu_op !== 4'd0 || alu_carry_in !== 1'b0 || alu_a !== 6'd0 || rsp_result !== 24'd0) begin
      errors++; $display("FAIL async_reset ready=%b valid=%b op=%h cin=%b a=%h result=%h want 1 0 0 0 0 0", req_ready, rsp_valid, alu_op, alu_carry_in, alu_a, rsp_result);
    end
    step();
    reset = 1'b0;
    step();
    step();
    checks++;
    if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL reset_discard valid=%b ready=%b want 0 1", rsp_valid, req_ready);
    end
    send(4'b0010, 24'h000003, 24'h000004, lat);
    checks++;
    if (lat !== 5 || rsp_result !== 24'h000007 || rsp_carry !== 1'b0 || rsp_zero !== 1'b0) begin
      errors++; $display("FAIL post_reset_add lat=%0d result=%h c=%b z=%b want 5 000007 0 0", lat, rsp_result, rsp_carry, rsp_zero);
    end
    release_rsp();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0;
    req_op = 4'd0; req_a = 24'd0; req_b = 24'd0;
    #12;
    test_reset();
    reset = 1'b0;
    step();
    test_add_carry();
    test_sub();
    test_add_ovf_and();
    test_back_to_back();
    test_illegal();
    test_reset_midrun();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
